// File: rtl/final_addition_deskew.sv
// Realigns the staggered slice outputs of a pipelined adder into one aligned sum.
// Optional macro FINAL_ADDITION_DESKEW_CNT_EN adds a saturating 16-bit out_count.

module deskew_lane #(
  parameter int PSW   = 2,
  parameter int DEPTH = 1,
  parameter int OFF_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PSW-1:0]   slice_in,
  input  logic [OFF_W-1:0] off,
  output logic [PSW-1:0]   aligned
);
  logic [DEPTH:1][PSW-1:0] dly;
  logic [DEPTH:0][PSW-1:0] tap;

  // tap[i] is the slice value captured i cycles ago; tap[0] is the live input
  assign tap     = {dly, slice_in};
  assign aligned = tap[off];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dly <= '0;
    else        dly <= tap[DEPTH-1:0];
  end
endmodule

module final_addition_deskew #(
  parameter int WIDTH            = 16,
  parameter int PIPE_STAGE_WIDTH = 2,
  parameter int PIPELINE_BITS    = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PIPELINE_BITS-1:0] pipes,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         sum_in,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     cfg_err,
`ifdef FINAL_ADDITION_DESKEW_CNT_EN
  output logic [15:0]              out_count,
`endif
  output logic                     busy
);
  localparam int N = WIDTH / PIPE_STAGE_WIDTH;

  // Arrival delay of slice k: number of enabled stages at or below it.
  function automatic int dly_of(input int p, input int k);
    int inv, c;
    inv = (p >= 1 && p <= 4) ? 5 - p : 0;
    c   = 0;
    for (int i = 0; i <= k; i++)
      if (i != N-1 && inv != 0 && ((N-1-i) % inv) == 0) c++;
    return c;
  endfunction

  function automatic int lat_max();
    int m;
    m = 0;
    for (int p = 1; p < 5; p++)
      if (dly_of(p, N-1) > m) m = dly_of(p, N-1);
    return m;
  endfunction

  localparam int LMAX  = lat_max();
  localparam int DEPTH = (LMAX > 0) ? LMAX : 1;
  localparam int OFF_W = $clog2(DEPTH + 1);

  function automatic logic [4:0][N-1:0][OFF_W-1:0] off_table();
    logic [4:0][N-1:0][OFF_W-1:0] t;
    for (int p = 0; p < 5; p++)
      for (int k = 0; k < N; k++)
        t[p][k] = OFF_W'(dly_of(p, N-1) - dly_of(p, k));
    return t;
  endfunction

  function automatic logic [4:0][OFF_W-1:0] lat_table();
    logic [4:0][OFF_W-1:0] t;
    for (int p = 0; p < 5; p++) t[p] = OFF_W'(dly_of(p, N-1));
    return t;
  endfunction

  localparam logic [4:0][N-1:0][OFF_W-1:0] OFF_TBL = off_table();
  localparam logic [4:0][OFF_W-1:0]        LAT_TBL = lat_table();

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]                        state;
  logic [PIPELINE_BITS-1:0]          pipes_q, pipes_eff;
  logic                              accept, inflight, out_vld_d;
  logic [OFF_W-1:0]                  lat;
  logic [N-1:0][OFF_W-1:0]           off;
  logic [DEPTH:1]                    vld_q;
  logic [DEPTH:0]                    vld_pipe;
  logic [N-1:0][PIPE_STAGE_WIDTH-1:0] aligned;

  assign cfg_err   = (32'(pipes) > 32'd4);
  assign pipes_eff = cfg_err ? '0 : pipes;
  assign in_ready  = (state == RUN);
  assign accept    = in_valid && in_ready;
  assign vld_pipe  = {vld_q, accept};
  assign out_vld_d = vld_pipe[lat];
  assign busy      = (state == DRAIN) || inflight;

  always_comb begin
    lat = LAT_TBL[0];
    off = OFF_TBL[0];
    case (pipes_q)
      PIPELINE_BITS'(1): begin lat = LAT_TBL[1]; off = OFF_TBL[1]; end
      PIPELINE_BITS'(2): begin lat = LAT_TBL[2]; off = OFF_TBL[2]; end
      PIPELINE_BITS'(3): begin lat = LAT_TBL[3]; off = OFF_TBL[3]; end
      PIPELINE_BITS'(4): begin lat = LAT_TBL[4]; off = OFF_TBL[4]; end
      default: ;
    endcase
  end

  // Bits above the current latency are stale history and never count as in flight
  always_comb begin
    inflight = 1'b0;
    for (int i = 1; i <= DEPTH; i++)
      if (OFF_W'(i) <= lat) inflight = inflight | vld_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      pipes_q <= '0;
      vld_q   <= '0;
    end else begin
      vld_q <= vld_pipe[DEPTH-1:0];
      case (state)
        RUN:   if (pipes_eff != pipes_q) state <= DRAIN;
        DRAIN: if (!inflight) begin
          state   <= RUN;
          pipes_q <= pipes_eff;
          // stale history must not alias into a longer new latency
          vld_q   <= '0;
        end
        default: state <= RUN;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    deskew_lane #(.PSW(PIPE_STAGE_WIDTH), .DEPTH(DEPTH), .OFF_W(OFF_W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .slice_in (sum_in[g*PIPE_STAGE_WIDTH +: PIPE_STAGE_WIDTH]),
      .off      (off[g]),
      .aligned  (aligned[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      out_valid <= out_vld_d;
      if (out_vld_d) out_sum <= aligned;
    end
  end

`ifdef FINAL_ADDITION_DESKEW_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_count <= '0;
    else if (out_valid && out_count != 16'hFFFF) out_count <= out_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_final_addition_deskew.sv
// Randomized bench for final_addition_deskew: staggered slices are driven from
// a schedule and results checked against an issue-order expectation ring.
module tb_final_addition_deskew;
  localparam int W = 16, PSW = 2, N = 8, PB = 3;

  logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [PB-1:0] pipes = '0;
  logic [W-1:0]  sum_in = '0;
  logic          in_ready, out_valid, cfg_err, busy;
  logic [W-1:0]  out_sum;

  int vectors = 0, errors = 0, edge_n = 0;
  bit [PSW-1:0] sv [N][64];
  bit           ss [N][64];
  logic [W-1:0] exp_val [64];
  bit           exp_set [64];
  logic [W-1:0] m_last;
  int           m_pq, m_pending;

  final_addition_deskew #(.WIDTH(W), .PIPE_STAGE_WIDTH(PSW), .PIPELINE_BITS(PB)) dut (
    .clk(clk), .rst_n(rst_n), .pipes(pipes), .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .out_valid(out_valid), .out_sum(out_sum), .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Slice arrival delay from the stage-enable rule: count enabled stages in slices 0..k.
  function automatic int dly(input int p, input int k);
    int inv, c;
    inv = (p >= 1 && p <= 4) ? 5 - p : 0;
    c = 0;
    for (int i = 0; i <= k; i++)
      if (i != N-1 && inv != 0 && ((N-1-i) % inv) == 0) c++;
    return c;
  endfunction

  // Drives each slice with its scheduled value, or noise when nothing is due.
  always @(posedge clk) begin : drv
    int idx;
    edge_n++;
    #2;
    idx = (edge_n + 1) % 64;
    for (int k = 0; k < N; k++) begin
      sum_in[k*PSW +: PSW] = ss[k][idx] ? sv[k][idx] : PSW'($urandom);
      ss[k][idx] = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) exp_set[i] = 1'b0;
    m_last = '0; m_pending = 0;
  endtask

  task automatic issue(input logic [W-1:0] v);
    int e;
    e = edge_n + 1;
    in_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      sv[k][(e + dly(m_pq, k)) % 64] = v[k*PSW +: PSW];
      ss[k][(e + dly(m_pq, k)) % 64] = 1'b1;
    end
    exp_val[(e + dly(m_pq, N-1)) % 64] = v;
    exp_set[(e + dly(m_pq, N-1)) % 64] = 1'b1;
    m_pending++;
  endtask

  task automatic model_step(output bit ev);
    int s;
    s = edge_n % 64;
    ev = exp_set[s];
    if (ev) begin
      m_last = exp_val[s]; exp_set[s] = 1'b0; m_pending--;
    end
  endtask

  task automatic configure(input int p);
    bit same;
    int eff;
    eff = (p > 4) ? 0 : p;
    same = (eff == m_pq);
    pipes = PB'(p); in_valid = 1'b0;
    tick();
    vectors++;
    if (in_ready !== same) begin errors++; $display("FAIL cfg_drain_entry p=%0d: in_ready=%b want %b", p, in_ready, same); end
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL cfg_drain_exit p=%0d: in_ready=%b want 1", p, in_ready); end
    m_pq = eff;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pipes = '0; in_valid = 1'b0;
    model_clear(); m_pq = 0;
    tick(); tick();
    vectors += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (out_sum !== '0) begin errors++; $display("FAIL reset_out_sum: got %h want 0000", out_sum); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_first_after_reset();
    bit ev;
    issue(16'h0003);
    for (int i = 0; i < 3; i++) begin
      tick(); in_valid = 1'b0;
      model_step(ev);
      vectors++;
      if (out_valid !== ev || out_sum !== m_last) begin
        errors++; $display("FAIL first_txn cyc %0d: valid=%b sum=%h want %b %h", i, out_valid, out_sum, ev, m_last);
      end
    end
  endtask

  task automatic test_single();
    bit ev;
    logic [W-1:0] v;
    for (int p = 0; p < 5; p++) begin
      configure(p);
      v = (p == 4) ? 16'h2392 : W'($urandom);
      issue(v);
      tick(); in_valid = 1'b0;
      for (int i = 0; i < dly(p, N-1) + 3; i++) begin
        if (i > 0) tick();
        model_step(ev);
        vectors++;
        if (out_valid !== ev || out_sum !== m_last || busy !== (m_pending > 0)) begin
          errors++;
          $display("FAIL single p=%0d cyc %0d: valid=%b sum=%h busy=%b want %b %h %b",
                   p, i, out_valid, out_sum, busy, ev, m_last, m_pending > 0);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int ps [5] = '{3, 0, 4, 2, 1};
    logic [W-1:0] fixed [3] = '{16'h0001, 16'hFFFF, 16'h8000};
    bit ev;
    int n, p;
    for (int t = 0; t < 5; t++) begin
      p = ps[t];
      configure(p);
      n = $urandom_range(4, 10);
      for (int i = 0; i < n + dly(p, N-1) + 2; i++) begin
        if (i < n && ((p == 3 && i < 3) || $urandom_range(0, 3) != 0))
          issue((p == 3 && i < 3) ? fixed[i] : W'($urandom));
        else
          in_valid = 1'b0;
        tick();
        model_step(ev);
        vectors++;
        if (out_valid !== ev || out_sum !== m_last) begin
          errors++; $display("FAIL b2b p=%0d cyc %0d: valid=%b sum=%h want %b %h", p, i, out_valid, out_sum, ev, m_last);
        end
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reconfig();
    bit ev, rdy;
    int drain;
    configure(4);
    issue(W'($urandom));
    tick(); in_valid = 1'b0;
    model_step(ev);
    pipes = PB'(1);
    tick();
    model_step(ev);
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reconfig_ready_low: in_ready=%b want 0", in_ready); end
    in_valid = 1'b1;  // must be ignored while draining
    rdy = 1'b0; drain = 1;
    for (int i = 0; i < 12 && !rdy; i++) begin
      tick(); in_valid = 1'b0;
      model_step(ev);
      vectors++;
      if (out_valid !== ev || out_sum !== m_last) begin
        errors++; $display("FAIL reconfig_out cyc %0d: valid=%b sum=%h want %b %h", i, out_valid, out_sum, ev, m_last);
      end
      if (in_ready === 1'b1) rdy = 1'b1;
      else begin
        drain++;
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reconfig_busy cyc %0d: busy=%b want 1", i, busy); end
      end
    end
    vectors++;
    if (!rdy || drain > 8 || m_pending != 0) begin
      errors++; $display("FAIL reconfig_drain: ready=%b drain=%0d pending=%0d want 1 <=8 0", rdy, drain, m_pending);
    end
    m_pq = 1;
    issue(W'($urandom));
    for (int i = 0; i < 3; i++) begin
      tick(); in_valid = 1'b0;
      model_step(ev);
      vectors++;
      if (out_valid !== ev || out_sum !== m_last) begin
        errors++; $display("FAIL reconfig_newlat cyc %0d: valid=%b sum=%h want %b %h", i, out_valid, out_sum, ev, m_last);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit ev;
    configure(4);
    issue(W'($urandom));
    tick(); in_valid = 1'b0; model_step(ev);
    tick(); model_step(ev);
    tick(); model_step(ev);
    rst_n = 1'b0;
    #1;
    model_clear(); m_pq = 0;
    vectors++;
    if (out_valid !== 1'b0 || out_sum !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_state: valid=%b sum=%h busy=%b ready=%b want 0 0000 0 1", out_valid, out_sum, busy, in_ready);
    end
    tick(); tick();
    rst_n = 1'b1;
    configure(4);
    for (int i = 0; i < 10; i++) begin
      tick();
      model_step(ev);
      vectors++;
      if (out_valid !== ev || out_sum !== m_last) begin
        errors++; $display("FAIL midreset_ghost cyc %0d: valid=%b sum=%h want %b %h", i, out_valid, out_sum, ev, m_last);
      end
    end
  endtask

  task automatic test_cfg_err();
    bit ev;
    configure(5);
    vectors++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_set: got %b want 1", cfg_err); end
    issue(16'h1234);
    for (int i = 0; i < 3; i++) begin
      tick(); in_valid = 1'b0;
      model_step(ev);
      vectors++;
      if (out_valid !== ev || out_sum !== m_last) begin
        errors++; $display("FAIL cfg_err_txn cyc %0d: valid=%b sum=%h want %b %h", i, out_valid, out_sum, ev, m_last);
      end
    end
    configure(0);
    vectors++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear: got %b want 0", cfg_err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_after_reset();
    test_single();
    test_back_to_back();
    test_reconfig();
    test_reset_midflight();
    test_cfg_err();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
